alu_sequencer: RTL and testbench
================================

# alu_sequencer

Multi-cycle execute controller for the 16-bit combinational ALU. It accepts one decoded instruction at a time over a valid/ready handshake, reads operands from the register file, and drives the ALU opcode and operand ports. Variable-count shifts are built by iterating the ALU's single-bit shift. The block writes the result back and keeps the processor status register (PSR) of latched `CLFZN` flags.

## Interface
- No parameters; data width 16, register address 4, immediate 8.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  instruction offered
- req_ready  out  1  block can accept (high only in IDLE)
- req_op  in  4  opcode
- req_ext  in  4  opcode extension
- req_rdest  in  4  destination / first-operand register
- req_rsrc  in  4  source register
- req_imm  in  8  immediate
- rf_raddr_a, rf_raddr_b  out  4  register-file read addresses (rsrc, rdest)
- rf_rdata_a, rf_rdata_b  in  16  combinational read data
- rf_we  out  1  write enable
- rf_waddr  out  4  write address
- rf_wdata  out  16  write data
- alu_a, alu_b  out  16  ALU operands
- alu_opcode, alu_opext  out  4  ALU opcode and extension
- alu_s  in  16  ALU result
- alu_clfzn  in  5  ALU flags
- psr  out  5  latched flags {C,L,F,Z,N}
- done  out  1  one-cycle pulse in the writeback cycle

## Operation
- Operand A is Rsrc or the extended immediate. Operand B is Rdest. SUB/SUBI therefore compute Rdest − A.
- Immediate extension:
  - ADDI, SUBI, CMPI: sign-extend imm.
  - ADDUI, MOVI: zero-extend imm.
  - MOVIU: alu_a = Rdest, alu_b = {8'h00, imm}.
- Shift ops:
  - Covered ops: LSH 0000_1100, RSH 0000_1110, ALSH 0000_0111, ARSH 0000_1000, RSHI 1110_xxxx.
  - Operand is Rdest, driven on alu_a.
  - Count is rf_rdata_a[3:0] for register forms and imm[3:0] for RSHI.
- Write-back: every op except CMP, CMPI and NOP (any opcode the ALU decodes as default).
- PSR: loads alu_clfzn verbatim only for ADD, ADDI, ADDU, ADDUI, SUB, SUBI, CMP, CMPI. All other ops leave PSR unchanged.
- States:
  - IDLE: req_ready=1. When req_valid is high, capture all req_* fields → EXEC.
  - EXEC:
    - Non-shift: latch result (and PSR if the op updates it) → WB.
    - Shift with count 0: result = Rdest → WB.
    - Shift with count ≥ 1: acc ← alu_s, remaining ← count−1. Go to WB if remaining = 0, else SHIFT.
  - SHIFT: alu_a = acc, acc ← alu_s, remaining decrements. When remaining reaches 0 → WB.
  - WB: rf_we as decoded, rf_waddr = rdest, rf_wdata = result, done=1 → IDLE.
- All req_* inputs are ignored outside IDLE.

## Timing
- Request accepted at edge 0 (req_valid & req_ready).
- Non-shift ops and zero-count shifts: EXEC in cycle 1, WB in cycle 2.
- Shift of count n ≥ 1: EXEC in cycle 1, SHIFT in cycles 2..n, WB in cycle n+1. Count 15 takes 16 cycles to WB.
- PSR updates on the edge that ends EXEC and is visible in the WB cycle.
- Back-to-back: the next request can be accepted in the cycle after WB. That request reads the register file after the write edge, so there is no hazard (register file writes on the clock edge).
- Reset values:
  - State IDLE, req_ready=1.
  - psr=0, done=0, rf_we=0; all address, data and ALU outputs 0.
- Reset asserted mid-instruction: the instruction is abandoned, with no write and no PSR change.

## Structure
- Shared header `alu_defs.vh` holds:
  - opcode/extension constants (ADD 0000_0101, ADDI 0101, ADDU 0000_0110, ADDUI 0110, SUB 0000_1001, SUBI 1001, CMP 0011, CMPI 1011, MOV 0000_1101, MOVI 1000, MOVIU 0111, shifts above);
  - PSR bit indices;
  - state encodings.
- The ALU is instantiated beside this block, not inside it.
- One natural sub-module: `imm_extend` (imm, op → 16-bit operand).

## Test plan
- ADD, R1=16'h7FFF, R2=16'h0001 (rdest=R1, rsrc=R2) → R1=16'h8000 in cycle 2; psr = alu_clfzn with F=1.
- SUBI, rdest R3=16'h0005, imm=8'hFF (−1) → R3=16'h0006; PSR updated; done pulses once.
- RSHI, R4=16'h8000, imm=8'h0F → 15 ALU iterations, R4=16'h0001; WB in cycle 16; req_ready low throughout.
- LSH, count register = 0, R5=16'h1234 → R5 unchanged; WB in cycle 2.
- CMP, R6=R7=16'h00AA → rf_we never asserted; psr = alu_clfzn. A following AND leaves psr unchanged.
- rst_n pulsed low during SHIFT of an ARSH with count 8 → no write, psr=0, req_ready=1 immediately. The next request executes normally.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU execute sequencer: opcode/extension
// constants, PSR layout, FSM states and instruction decode helpers.
package alu_sequencer_pkg;

  // Register-form instructions share opcode 0000 and are told apart by ext
  localparam logic [3:0] OP_RTYPE = 4'b0000;

  localparam logic [3:0] EXT_NOP  = 4'b0000;
  localparam logic [3:0] EXT_ADD  = 4'b0101;
  localparam logic [3:0] EXT_ADDU = 4'b0110;
  localparam logic [3:0] EXT_SUB  = 4'b1001;
  localparam logic [3:0] EXT_LSH  = 4'b1100;
  localparam logic [3:0] EXT_RSH  = 4'b1110;
  localparam logic [3:0] EXT_ALSH = 4'b0111;
  localparam logic [3:0] EXT_ARSH = 4'b1000;

  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_ADDUI = 4'b0110;
  localparam logic [3:0] OP_SUBI  = 4'b1001;
  localparam logic [3:0] OP_CMP   = 4'b0011;
  localparam logic [3:0] OP_CMPI  = 4'b1011;
  localparam logic [3:0] OP_MOVI  = 4'b1000;
  localparam logic [3:0] OP_MOVIU = 4'b0111;
  localparam logic [3:0] OP_RSHI  = 4'b1110;

  // PSR layout: member order fixes the bit indices, C is bit 4, N is bit 0
  typedef struct packed {
    logic c;
    logic l;
    logic f;
    logic z;
    logic n;
  } psr_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_WB    = 2'd3
  } state_t;

  // Instruction fields captured at acceptance
  typedef struct packed {
    logic [3:0] op;
    logic [3:0] ext;
    logic [3:0] rdest;
    logic [3:0] rsrc;
    logic [7:0] imm;
  } instr_t;

  // Ops implemented by iterating the ALU's single-bit shift
  function automatic logic is_shift(input logic [3:0] op, input logic [3:0] ext);
    if (op == OP_RSHI) begin
      return 1'b1;
    end
    return (op == OP_RTYPE) &&
           (ext == EXT_LSH || ext == EXT_RSH || ext == EXT_ALSH || ext == EXT_ARSH);
  endfunction

  // Arithmetic and compare ops are the only ones that load the PSR
  function automatic logic updates_psr(input logic [3:0] op, input logic [3:0] ext);
    if (op == OP_RTYPE) begin
      return (ext == EXT_ADD) || (ext == EXT_ADDU) || (ext == EXT_SUB);
    end
    return (op == OP_ADDI) || (op == OP_ADDUI) || (op == OP_SUBI) ||
           (op == OP_CMP)  || (op == OP_CMPI);
  endfunction

  // Compares and NOP produce no register result
  function automatic logic writes_back(input logic [3:0] op, input logic [3:0] ext);
    if (op == OP_CMP || op == OP_CMPI) begin
      return 1'b0;
    end
    return !((op == OP_RTYPE) && (ext == EXT_NOP));
  endfunction

  // Ops whose A operand is the extended immediate instead of Rsrc
  function automatic logic uses_imm(input logic [3:0] op);
    return (op == OP_ADDI) || (op == OP_ADDUI) || (op == OP_SUBI) ||
           (op == OP_CMPI) || (op == OP_MOVI);
  endfunction

  // Signed immediates; every other immediate is zero-extended
  function automatic logic sign_extends(input logic [3:0] op);
    return (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_CMPI);
  endfunction

endpackage

// File: rtl/alu_sequencer_imm_extend.sv
// Widens the 8-bit immediate to a 16-bit ALU operand, signed or unsigned
// depending on the opcode.
module imm_extend
  import alu_sequencer_pkg::*;
(
  input  logic [7:0]  imm,
  input  logic [3:0]  op,
  output logic [15:0] operand
);

  // Sign-extend for the signed arithmetic/compare immediates, else zero-extend
  always_comb begin
    operand = {8'h00, imm};
    if (sign_extends(op)) begin
      operand = {{8{imm[7]}}, imm};
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle execute controller for the external 16-bit ALU. Accepts one
// instruction per handshake, feeds operands from the register file, builds
// multi-bit shifts from repeated single-bit ALU shifts, writes the result
// back and maintains the latched CLFZN status flags.
module alu_sequencer
  import alu_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,

  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [3:0]  req_ext,
  input  logic [3:0]  req_rdest,
  input  logic [3:0]  req_rsrc,
  input  logic [7:0]  req_imm,

  output logic [3:0]  rf_raddr_a,
  output logic [3:0]  rf_raddr_b,
  input  logic [15:0] rf_rdata_a,
  input  logic [15:0] rf_rdata_b,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [15:0] rf_wdata,

  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_opcode,
  output logic [3:0]  alu_opext,
  input  logic [15:0] alu_s,
  input  logic [4:0]  alu_clfzn,

  output logic [4:0]  psr,
  output logic        done
);

  state_t      state_reg, state_next;
  instr_t      instr_reg, instr_next;
  logic [15:0] acc_reg, acc_next;
  logic [15:0] result_reg, result_next;
  logic [3:0]  remaining_reg, remaining_next;
  psr_t        psr_reg, psr_next;

  logic [15:0] imm_operand;
  logic        shift_op;
  logic [3:0]  shift_count;

  imm_extend u_imm_extend (
    .imm     (instr_reg.imm),
    .op      (instr_reg.op),
    .operand (imm_operand)
  );

  // Port A always addresses Rsrc, port B always Rdest
  assign rf_raddr_a  = instr_reg.rsrc;
  assign rf_raddr_b  = instr_reg.rdest;
  assign psr         = psr_reg;
  assign shift_op    = is_shift(instr_reg.op, instr_reg.ext);
  // RSHI takes its count from the immediate, register shifts from Rsrc
  assign shift_count = (instr_reg.op == OP_RSHI) ? instr_reg.imm[3:0] : rf_rdata_a[3:0];

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath registers: captured instruction, shift accumulator, result, PSR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_reg     <= '0;
      acc_reg       <= '0;
      result_reg    <= '0;
      remaining_reg <= '0;
      psr_reg       <= '0;
    end else begin
      instr_reg     <= instr_next;
      acc_reg       <= acc_next;
      result_reg    <= result_next;
      remaining_reg <= remaining_next;
      psr_reg       <= psr_next;
    end
  end

  // Next-state, datapath updates and output decode
  always_comb begin
    state_next     = state_reg;
    instr_next     = instr_reg;
    acc_next       = acc_reg;
    result_next    = result_reg;
    remaining_next = remaining_reg;
    psr_next       = psr_reg;

    req_ready  = 1'b0;
    rf_we      = 1'b0;
    rf_waddr   = 4'h0;
    rf_wdata   = 16'h0000;
    alu_a      = 16'h0000;
    alu_b      = 16'h0000;
    alu_opcode = 4'h0;
    alu_opext  = 4'h0;
    done       = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          instr_next = '{op: req_op, ext: req_ext, rdest: req_rdest,
                         rsrc: req_rsrc, imm: req_imm};
          state_next = ST_EXEC;
        end
      end

      ST_EXEC: begin
        alu_opcode = instr_reg.op;
        alu_opext  = instr_reg.ext;
        if (shift_op) begin
          // First single-bit shift of Rdest; a zero count passes Rdest through
          alu_a = rf_rdata_b;
          if (shift_count == 4'd0) begin
            result_next = rf_rdata_b;
            state_next  = ST_WB;
          end else begin
            acc_next       = alu_s;
            result_next    = alu_s;
            remaining_next = shift_count - 4'd1;
            state_next     = (shift_count == 4'd1) ? ST_WB : ST_SHIFT;
          end
        end else begin
          if (instr_reg.op == OP_MOVIU) begin
            alu_a = rf_rdata_b;
            alu_b = {8'h00, instr_reg.imm};
          end else begin
            alu_a = uses_imm(instr_reg.op) ? imm_operand : rf_rdata_a;
            alu_b = rf_rdata_b;
          end
          result_next = alu_s;
          if (updates_psr(instr_reg.op, instr_reg.ext)) begin
            psr_next = psr_t'(alu_clfzn);
          end
          state_next = ST_WB;
        end
      end

      ST_SHIFT: begin
        // Re-shift the accumulator by one bit until the count is used up
        alu_opcode     = instr_reg.op;
        alu_opext      = instr_reg.ext;
        alu_a          = acc_reg;
        acc_next       = alu_s;
        result_next    = alu_s;
        remaining_next = remaining_reg - 4'd1;
        if (remaining_reg == 4'd1) begin
          state_next = ST_WB;
        end
      end

      ST_WB: begin
        rf_we      = writes_back(instr_reg.op, instr_reg.ext);
        rf_waddr   = instr_reg.rdest;
        rf_wdata   = result_reg;
        done       = 1'b1;
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed testbench for alu_sequencer with a behavioural ALU and register
// file around the DUT.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0, req_ext = '0, req_rdest = '0, req_rsrc = '0;
  logic [7:0]  req_imm = '0;
  logic [3:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [15:0] rf_rdata_a, rf_rdata_b, rf_wdata;
  logic        rf_we;
  logic [15:0] alu_a, alu_b, alu_s;
  logic [3:0]  alu_opcode, alu_opext;
  logic [4:0]  alu_clfzn, psr;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [15:0] rf [16];
  logic        pre_we = 1'b0;
  logic [3:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;
  logic [16:0] wide;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_ext(req_ext), .req_rdest(req_rdest),
    .req_rsrc(req_rsrc), .req_imm(req_imm),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_opext(alu_opext),
    .alu_s(alu_s), .alu_clfzn(alu_clfzn),
    .psr(psr), .done(done)
  );

  // Register file: combinational read, write on the clock edge
  assign rf_rdata_a = rf[rf_raddr_a];
  assign rf_rdata_b = rf[rf_raddr_b];

  always @(posedge clk) begin
    if (pre_we) rf[pre_addr] <= pre_data;
    else if (rf_we) rf[rf_waddr] <= rf_wdata;
  end

  // Behavioural ALU; ops without flag logic report all-ones flags
  always_comb begin
    wide      = 17'h0;
    alu_s     = 16'h0000;
    alu_clfzn = 5'b11111;
    if ((alu_opcode == 4'b0000 && (alu_opext == 4'b0101 || alu_opext == 4'b0110)) ||
        alu_opcode == 4'b0101 || alu_opcode == 4'b0110) begin
      wide      = {1'b0, alu_a} + {1'b0, alu_b};
      alu_s     = wide[15:0];
      alu_clfzn = {wide[16], alu_a > alu_b,
                   (alu_a[15] == alu_b[15]) && (wide[15] != alu_a[15]),
                   wide[15:0] == 16'h0, wide[15]};
    end else if ((alu_opcode == 4'b0000 && alu_opext == 4'b1001) ||
                 alu_opcode == 4'b1001 || alu_opcode == 4'b0011 || alu_opcode == 4'b1011) begin
      wide      = {1'b0, alu_b} - {1'b0, alu_a};
      alu_s     = wide[15:0];
      alu_clfzn = {alu_b < alu_a, alu_a > alu_b,
                   (alu_a[15] != alu_b[15]) && (wide[15] != alu_b[15]),
                   wide[15:0] == 16'h0, wide[15]};
    end else if (alu_opcode == 4'b0000) begin
      case (alu_opext)
        4'b0001: alu_s = alu_a & alu_b;
        4'b1101: alu_s = alu_a;
        4'b1100, 4'b0111: alu_s = {alu_a[14:0], 1'b0};
        4'b1110: alu_s = {1'b0, alu_a[15:1]};
        4'b1000: alu_s = {alu_a[15], alu_a[15:1]};
        default: alu_s = 16'h0000;
      endcase
    end else begin
      case (alu_opcode)
        4'b1000: alu_s = alu_a;
        4'b0111: alu_s = {alu_b[7:0], alu_a[7:0]};
        4'b1110: alu_s = {1'b0, alu_a[15:1]};
        default: alu_s = 16'h0000;
      endcase
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [3:0] addr, input logic [15:0] data);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = addr; pre_data = data;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  // Issue one instruction and track it to write-back
  task automatic do_op(input string name, input logic [3:0] op, input logic [3:0] ext,
                       input logic [3:0] rd, input logic [3:0] rs, input logic [7:0] imm,
                       input logic [15:0] exp_val, input int exp_wb,
                       input logic [4:0] exp_psr, input int exp_we);
    int wb_cyc, we_cnt, rdy_cnt;
    logic [4:0] psr_wb;
    wb_cyc = 0; we_cnt = 0; rdy_cnt = 0; psr_wb = 5'h0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_ext = ext;
    req_rdest = rd; req_rsrc = rs; req_imm = imm;
    @(posedge clk);
    #1;
    // Garbage on the request bus must be ignored while busy
    req_valid = 1'b0; req_op = ~op; req_ext = ~ext;
    req_rdest = ~rd; req_rsrc = ~rs; req_imm = ~imm;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (rf_we) we_cnt++;
      if (req_ready) rdy_cnt++;
      if (done) begin
        wb_cyc = c;
        psr_wb = psr;
        break;
      end
    end
    check_eq({name, " wb_cycle"}, wb_cyc, exp_wb);
    check_eq({name, " psr"}, {27'h0, psr_wb}, {27'h0, exp_psr});
    check_eq({name, " rf_we_count"}, we_cnt, exp_we);
    check_eq({name, " ready_busy"}, rdy_cnt, 0);
    @(negedge clk);
    check_eq({name, " done_after"}, {31'h0, done}, 32'h0);
    check_eq({name, " ready_after"}, {31'h0, req_ready}, 32'h1);
    check_eq({name, " result"}, {16'h0, rf[rd]}, {16'h0, exp_val});
    $display("op %s wb_cycle %0d r%0d=%h psr=%b", name, wb_cyc, rd, rf[rd], psr_wb);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) preload(i[3:0], 16'h0000);
    preload(4'd1, 16'h7FFF);  preload(4'd2, 16'h0001);
    preload(4'd3, 16'h0005);  preload(4'd4, 16'h8000);
    preload(4'd5, 16'h1234);  preload(4'd10, 16'h0010);
    preload(4'd6, 16'h00AA);  preload(4'd7, 16'h00AA);
    preload(4'd8, 16'h8000);  preload(4'd9, 16'h0008);

    #1;
    check_eq("reset ready", {31'h0, req_ready}, 32'h1);
    check_eq("reset psr", {27'h0, psr}, 32'h0);
    check_eq("reset done", {31'h0, done}, 32'h0);
    check_eq("reset rf_we", {31'h0, rf_we}, 32'h0);
    check_eq("reset alu_ab", {alu_a, alu_b}, 32'h0);
    check_eq("reset wdata", {12'h0, rf_waddr, rf_wdata}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("ADD",  4'b0000, 4'b0101, 4'd1, 4'd2,  8'h00, 16'h8000, 2,  5'b00101, 1);
    do_op("SUBI", 4'b1001, 4'b0000, 4'd3, 4'd0,  8'hFF, 16'h0006, 2,  5'b11000, 1);
    do_op("RSHI", 4'b1110, 4'b0000, 4'd4, 4'd0,  8'h0F, 16'h0001, 16, 5'b11000, 1);
    do_op("LSH0", 4'b0000, 4'b1100, 4'd5, 4'd10, 8'h00, 16'h1234, 2,  5'b11000, 1);
    do_op("CMP",  4'b0011, 4'b0000, 4'd6, 4'd7,  8'h00, 16'h00AA, 2,  5'b00010, 0);
    do_op("AND",  4'b0000, 4'b0001, 4'd6, 4'd7,  8'h00, 16'h00AA, 2,  5'b00010, 1);

    // Abandon an ARSH by reset while it is iterating
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'b0000; req_ext = 4'b1000;
    req_rdest = 4'd8; req_rsrc = 4'd9; req_imm = 8'h00;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check_eq("arsh busy", {31'h0, req_ready}, 32'h0);
    rst_n = 1'b0;
    #1;
    check_eq("midrst ready", {31'h0, req_ready}, 32'h1);
    check_eq("midrst psr", {27'h0, psr}, 32'h0);
    check_eq("midrst rf_we", {31'h0, rf_we}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("midrst r8", {16'h0, rf[8]}, 32'h8000);
    $display("op ARSH_reset r8=%h psr=%b", rf[8], psr);

    do_op("MOV",  4'b0000, 4'b1101, 4'd11, 4'd2, 8'h00, 16'h0001, 2, 5'b00000, 1);
    do_op("ARSH", 4'b0000, 4'b1000, 4'd8,  4'd9, 8'h00, 16'hFF80, 9, 5'b00000, 1);
    do_op("MOVI", 4'b1000, 4'b0000, 4'd12, 4'd0, 8'hF0, 16'h00F0, 2, 5'b00000, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
